// File: rtl/rca_stream_sum.sv
// rtl/rca_stream_sum.sv - streaming multi-operand ripple-carry summer with valid/ready in/out
//
// rca_stream_sum: accumulates up to MAX_OPS WIDTH-bit operands per group and
// emits one OUT_W-bit sum per group.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept an operand (low in DONE and during/just after reset)
//   in_data    operand
//   in_last    final operand of the group
//   in_signed  group mode, sampled on the first beat (1 = two's complement)
//   out_valid  sum available
//   out_ready  consumer accepts sum
//   out_sum    group sum, modulo 2^OUT_W
//   out_count  number of operands summed
//   out_err    group closed at MAX_OPS without in_last
//
// rca_adder: plain W-bit ripple-carry adder, carry-out discarded (modulo 2^W).

module rca_adder #(
    parameter int W = 11
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    logic [W-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        // The top stage's carry-out is dropped: arithmetic wraps at 2^W.
        if (i < W - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end
endmodule

module rca_stream_sum #(
    parameter int WIDTH   = 8,
    parameter int MAX_OPS = 3,
    parameter int OUT_W   = WIDTH + $clog2(MAX_OPS) + 1,
    parameter int CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state, state_next;

    // Held low through reset and for the first edge after release, so the
    // block never accepts a beat while rst_n is low.
    logic run;

    logic             beat;
    logic             handshake;
    logic             mode_q;
    logic             mode_cur;
    logic             hit_max;
    logic             final_beat;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_in;
    logic [OUT_W-1:0] operand;
    logic [OUT_W-1:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        in_ready   = run && (state != DONE);
        out_valid  = (state == DONE);
        beat       = in_valid && in_ready;
        handshake  = out_valid && out_ready;
        // The first beat of a group sets the mode for its own extension too.
        mode_cur   = (state == IDLE) ? in_signed : mode_q;
        count_next = (state == IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
        hit_max    = (count_next == CNT_W'(MAX_OPS));
        final_beat = beat && (in_last || hit_max);
        state_next = state;
        case (state)
            IDLE, ACCUM: begin
                if (final_beat) begin
                    state_next = DONE;
                end else if (beat) begin
                    state_next = ACCUM;
                end
            end
            DONE: begin
                if (handshake) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign operand = mode_cur ? OUT_W'($signed(in_data)) : OUT_W'(in_data);
    assign acc_in  = (state == IDLE) ? '0 : acc_q;

    rca_adder #(.W(OUT_W)) u_adder (
        .a   (acc_in),
        .b   (operand),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            mode_q    <= 1'b0;
            count_q   <= '0;
            acc_q     <= '0;
            out_sum   <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (beat) begin
                acc_q   <= sum;
                count_q <= count_next;
                if (state == IDLE) begin
                    mode_q <= in_signed;
                end
            end
            // Result fields are captured once and then held until the next
            // group closes, independent of the accumulator being cleared.
            if (final_beat) begin
                out_sum   <= sum;
                out_count <= count_next;
                out_err   <= hit_max && !in_last;
            end
            if (handshake) begin
                acc_q   <= '0;
                count_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rca_stream_sum.sv
// tb/tb_rca_stream_sum.sv - self-checking bench for rca_stream_sum
module tb_rca_stream_sum;
    localparam int W  = 8;
    localparam int M  = 3;
    localparam int OW = 11;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          in_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic          out_err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] g_data [M];
    bit           g_last [M];

    logic [OW-1:0] act_sum;
    logic [CW-1:0] act_count;
    logic          act_err;

    rca_stream_sum #(.WIDTH(W), .MAX_OPS(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Reference: walk the group's beats, stop at in_last or at M operands.
    function automatic void model(input bit sgn, output int nbeats,
                                  output logic [OW-1:0] es, output int ec, output bit ee);
        int tot;
        tot    = 0;
        nbeats = 0;
        ee     = 1'b0;
        for (int i = 0; i < M; i++) begin
            nbeats++;
            tot += sgn ? int'($signed(g_data[i])) : int'(g_data[i]);
            if (g_last[i]) break;
            if (nbeats == M) ee = 1'b1;
        end
        ec = nbeats;
        es = OW'(tot);
    endfunction

    task automatic send_beat(input logic [W-1:0] d, input bit last, input bit sgn);
        int t;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        in_signed = sgn;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout in_ready=%b required=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic fetch_result();
        int t;
        t = 0;
        while (out_valid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL result_timeout out_valid=%b required=1", out_valid);
        end
        act_sum   = out_sum;
        act_count = out_count;
        act_err   = out_err;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Sends beats from g_data/g_last; later beats carry a random in_signed
    // that must be ignored.
    task automatic play_group(input bit sgn, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            send_beat(g_data[i], g_last[i], (i == 0) ? sgn : 1'($urandom));
        end
        fetch_result();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_sum, out_count, out_err} !== '0) begin
            errors++;
            $display("FAIL reset_state ready=%b valid=%b sum=%0d count=%0d err=%b required all 0",
                     in_ready, out_valid, out_sum, out_count, out_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready in_ready=%b required=1", in_ready);
        end
    endtask

    task automatic test_legacy();
        int nb, ec;
        logic [OW-1:0] es;
        bit ee;
        send_beat(8'd255, 1'b0, 1'b0);
        send_beat(8'd255, 1'b0, 1'b0);
        send_beat(8'd255, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_sum, out_count, out_err} !== {1'b1, 11'd765, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL legacy_255 valid=%b sum=%0d count=%0d err=%b required 1/765/3/0",
                     out_valid, out_sum, out_count, out_err);
        end
        fetch_result();
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < M; i++) begin
                g_data[i] = W'($urandom);
                g_last[i] = (i == M - 1);
            end
            model(1'b0, nb, es, ec, ee);
            play_group(1'b0, nb);
            checks++;
            if (act_sum !== es || act_count !== CW'(ec) || act_err !== ee) begin
                errors++;
                $display("FAIL legacy_random sum=%0d count=%0d err=%b required %0d/%0d/%b",
                         act_sum, act_count, act_err, es, ec, ee);
            end
        end
    endtask

    task automatic test_signed();
        for (int i = 0; i < M; i++) begin
            g_data[i] = 8'h80;
            g_last[i] = (i == M - 1);
        end
        play_group(1'b1, 3);
        checks++;
        if (act_sum !== 11'h680 || act_err !== 1'b0) begin
            errors++;
            $display("FAIL signed_min sum=%h err=%b required 680/0", act_sum, act_err);
        end
        play_group(1'b0, 3);
        checks++;
        if (act_sum !== 11'd384) begin
            errors++;
            $display("FAIL unsigned_80 sum=%0d required 384", act_sum);
        end
    endtask

    task automatic test_early();
        send_beat(8'd7, 1'b1, 1'b0);
        fetch_result();
        checks++;
        if (act_sum !== 11'd7 || act_count !== 2'd1 || act_err !== 1'b0) begin
            errors++;
            $display("FAIL early_single sum=%0d count=%0d err=%b required 7/1/0",
                     act_sum, act_count, act_err);
        end
        send_beat(8'd1, 1'b0, 1'b0);
        send_beat(8'd2, 1'b1, 1'b0);
        fetch_result();
        checks++;
        if (act_sum !== 11'd3 || act_count !== 2'd2) begin
            errors++;
            $display("FAIL early_pair sum=%0d count=%0d required 3/2", act_sum, act_count);
        end
    endtask

    task automatic test_back_pressure();
        send_beat(8'd10, 1'b0, 1'b0);
        send_beat(8'd20, 1'b0, 1'b0);
        send_beat(8'd30, 1'b1, 1'b0);
        in_valid  = 1'b1;
        in_data   = 8'd9;
        in_last   = 1'b1;
        in_signed = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({in_ready, out_valid, out_sum, out_count, out_err} !==
                {1'b0, 1'b1, 11'd60, 2'd3, 1'b0}) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d ready=%b valid=%b sum=%0d count=%0d err=%b required 0/1/60/3/0",
                         c, in_ready, out_valid, out_sum, out_count, out_err);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release valid=%b ready=%b required 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 11'd9 || out_count !== 2'd1) begin
            errors++;
            $display("FAIL backpressure_held_beat valid=%b sum=%0d count=%0d required 1/9/1",
                     out_valid, out_sum, out_count);
        end
        fetch_result();
    endtask

    task automatic test_truncation();
        send_beat(8'd1, 1'b0, 1'b0);
        send_beat(8'd2, 1'b0, 1'b0);
        send_beat(8'd3, 1'b0, 1'b0);
        fetch_result();
        checks++;
        if (act_sum !== 11'd6 || act_count !== 2'd3 || act_err !== 1'b1) begin
            errors++;
            $display("FAIL truncation sum=%0d count=%0d err=%b required 6/3/1",
                     act_sum, act_count, act_err);
        end
        send_beat(8'd4, 1'b0, 1'b0);
        send_beat(8'd5, 1'b0, 1'b0);
        send_beat(8'd6, 1'b1, 1'b0);
        fetch_result();
        checks++;
        if (act_sum !== 11'd15 || act_err !== 1'b0) begin
            errors++;
            $display("FAIL last_at_max sum=%0d err=%b required 15/0", act_sum, act_err);
        end
    endtask

    task automatic test_reset_mid_group();
        send_beat(8'd50, 1'b0, 1'b1);
        send_beat(8'd60, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_sum, out_count, out_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_clear ready=%b valid=%b sum=%0d count=%0d err=%b required all 0",
                     in_ready, out_valid, out_sum, out_count, out_err);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ready in_ready=%b required=0", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(8'd4, 1'b0, 1'b0);
        send_beat(8'd4, 1'b1, 1'b0);
        fetch_result();
        checks++;
        if (act_sum !== 11'd8 || act_count !== 2'd2 || act_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_next sum=%0d count=%0d err=%b required 8/2/0",
                     act_sum, act_count, act_err);
        end
    endtask

    task automatic test_random_groups();
        int nb, ec;
        logic [OW-1:0] es;
        bit ee, sgn;
        for (int k = 0; k < 40; k++) begin
            sgn = 1'($urandom);
            for (int i = 0; i < M; i++) begin
                g_data[i] = W'($urandom);
                g_last[i] = ($urandom_range(0, 2) == 0);
            end
            model(sgn, nb, es, ec, ee);
            play_group(sgn, nb);
            checks++;
            if (act_sum !== es || act_count !== CW'(ec) || act_err !== ee) begin
                errors++;
                $display("FAIL random_group k=%0d sgn=%b sum=%h count=%0d err=%b required %h/%0d/%b",
                         k, sgn, act_sum, act_count, act_err, es, ec, ee);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_legacy();
        test_signed();
        test_early();
        test_back_pressure();
        test_truncation();
        test_reset_mid_group();
        test_random_groups();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
